// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: pixel clock-enable, h/v counters, sync pulses, active window
// and line/frame strobes. A run/drain/idle FSM only starts or stops scanning on frame boundaries.
module vga_timing_ctrl #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       enable,
    output logic       pix_ce,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       line_start,
    output logic       frame_start,
    output logic       busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_q, video_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             active;
    logic             frame_end;

    assign active    = (state_q != IDLE);
    assign pix_ce    = active && (div_q == DIV_LAST);
    assign frame_end = pix_ce && (h_q == H_LAST) && (v_q == V_LAST);

    // Enable has priority over the drain exit, so a request on the last edge keeps scanning.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = DRAIN;
            DRAIN: begin
                if (enable)         state_d = RUN;
                else if (frame_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_d = '0;
        h_d   = '0;
        v_d   = '0;
        if (active) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
            h_d   = h_q;
            v_d   = v_q;
            if (pix_ce) begin
                if (h_q == H_LAST) begin
                    h_d = '0;
                    v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
                end else begin
                    h_d = h_q + 10'd1;
                end
            end
        end
    end

    // Decoded from the next counter values so they line up with h_count/v_count.
    always_comb begin
        hsync_d       = ~HS_POL;
        vsync_d       = ~VS_POL;
        video_d       = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (state_d != IDLE) begin
            hsync_d       = (h_d >= HS_START && h_d <= HS_END) ? HS_POL : ~HS_POL;
            vsync_d       = (v_d >= VS_START && v_d <= VS_END) ? VS_POL : ~VS_POL;
            video_d       = (h_d < H_ACT) && (v_d < V_ACT);
            line_start_d  = (h_d == 10'd0) && (pix_ce || !active);
            frame_start_d = line_start_d && (v_d == 10'd0);
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            video_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_q       <= video_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign h_count     = h_q;
    assign v_count     = v_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign busy        = active;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl on a shrunken raster so whole frames fit in a short run;
// expectations come from a scan-time model (elapsed cycles -> pixel position).
module tb_vga_timing_ctrl;

    localparam int CD = 4;
    localparam int HA = 8, HF = 2, HSW = 3, HBP = 2;
    localparam int VA = 5, VF = 1, VSW = 2, VBP = 1;
    localparam int HT = HA + HF + HSW + HBP;
    localparam int VT = VA + VF + VSW + VBP;
    localparam int LINE  = CD * HT;
    localparam int FRAME = LINE * VT;
    localparam bit HSP = 1'b0;
    localparam bit VSP = 1'b1;
    localparam int OW  = 27;
    localparam logic [OW-1:0] RST_VEC = {1'b0, 10'd0, 10'd0, ~HSP, ~VSP, 4'b0000};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       en1 = 1'b0;

    logic       pix_ce, hsync, vsync, video_on, line_start, frame_start, busy;
    logic [9:0] h_count, v_count;
    logic       pix_ce1, hsync1, vsync1, video_on1, line_start1, frame_start1, busy1;
    logic [9:0] h_count1, v_count1;
    logic [OW-1:0] act;

    int checks = 0;
    int failures = 0;
    int ncyc = 0;

    always #5 clk = ~clk;
    always @(negedge clk) ncyc <= ncyc + 1;

    vga_timing_ctrl #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VBP), .HS_POL(HSP), .VS_POL(VSP)
    ) dut (
        .clk_in(clk), .rst(rst), .enable(enable), .pix_ce(pix_ce),
        .h_count(h_count), .v_count(v_count), .hsync(hsync), .vsync(vsync),
        .video_on(video_on), .line_start(line_start), .frame_start(frame_start), .busy(busy)
    );

    vga_timing_ctrl #(
        .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VBP), .HS_POL(HSP), .VS_POL(VSP)
    ) dut_div1 (
        .clk_in(clk), .rst(rst), .enable(en1), .pix_ce(pix_ce1),
        .h_count(h_count1), .v_count(v_count1), .hsync(hsync1), .vsync(vsync1),
        .video_on(video_on1), .line_start(line_start1), .frame_start(frame_start1), .busy(busy1)
    );

    assign act = {pix_ce, h_count, v_count, hsync, vsync, video_on, line_start, frame_start, busy};

    // Reference model: scan time since the frame began; stop only when the final edge of a
    // frame samples enable low after the previous edge also sampled it low.
    bit m_busy = 1'b0;
    int m_t = 0;
    bit m_en_prev = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy    <= 1'b0;
            m_t       <= 0;
            m_en_prev <= 1'b0;
        end else begin
            if (!m_busy) begin
                if (enable) begin
                    m_busy <= 1'b1;
                    m_t    <= 0;
                end
            end else if (m_t == FRAME - 1 && !enable && !m_en_prev) begin
                m_busy <= 1'b0;
                m_t    <= 0;
            end else begin
                m_t <= (m_t + 1) % FRAME;
            end
            m_en_prev <= enable;
        end
    end

    function automatic logic [OW-1:0] model_out(input bit busy_i, input int t);
        int p, h, v;
        logic pc, hs, vs, vid, ls, fs;
        if (!busy_i) return RST_VEC;
        p   = t / CD;
        h   = p % HT;
        v   = (p / HT) % VT;
        pc  = (t % CD == CD - 1);
        hs  = (h >= HA + HF && h < HA + HF + HSW) ? HSP : ~HSP;
        vs  = (v >= VA + VF && v < VA + VF + VSW) ? VSP : ~VSP;
        vid = (h < HA) && (v < VA);
        ls  = (t % LINE == 0);
        fs  = (t == 0);
        return {pc, 10'(h), 10'(v), hs, vs, vid, ls, fs, 1'b1};
    endfunction

    task automatic wait_pos(input int h, input int v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME && !ok; i++) begin
            @(negedge clk);
            if (h_count == 10'(h) && v_count == 10'(v)) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (act !== RST_VEC) begin
                failures++;
                $display("FAIL reset_values act=%h exp=%h", act, RST_VEC);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b1 || line_start !== 1'b1 || busy !== 1'b1 ||
            h_count !== 10'd0 || v_count !== 10'd0 || pix_ce !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_frame act=%h exp fs=1 ls=1 busy=1 h=0 v=0 ce=0", act);
        end
        repeat (2 * CD) begin
            @(negedge clk);
            checks++;
            if (act !== model_out(m_busy, m_t)) begin
                failures++;
                $display("FAIL reset_start act=%h exp=%h", act, model_out(m_busy, m_t));
            end
        end
    endtask

    task automatic test_pixel_rate();
        int last = -1;
        for (int n = 0; n < 3 * LINE; n++) begin
            @(negedge clk);
            checks++;
            if (act !== model_out(m_busy, m_t)) begin
                failures++;
                $display("FAIL pixel_scan act=%h exp=%h", act, model_out(m_busy, m_t));
            end
            if (pix_ce) begin
                if (last >= 0) begin
                    checks++;
                    if (n - last != CD) begin
                        failures++;
                        $display("FAIL pix_ce_period got=%0d exp=%0d", n - last, CD);
                    end
                end
                last = n;
            end
        end
    endtask

    task automatic test_frame();
        int ls_last = -1;
        int fs_last = -1;
        for (int n = 0; n < 2 * FRAME + LINE; n++) begin
            @(negedge clk);
            checks++;
            if (act !== model_out(m_busy, m_t)) begin
                failures++;
                $display("FAIL frame_scan act=%h exp=%h", act, model_out(m_busy, m_t));
            end
            if (line_start) begin
                if (ls_last >= 0) begin
                    checks++;
                    if (n - ls_last != LINE) begin
                        failures++;
                        $display("FAIL line_period got=%0d exp=%0d", n - ls_last, LINE);
                    end
                end
                ls_last = n;
            end
            if (frame_start) begin
                if (fs_last >= 0) begin
                    checks++;
                    if (n - fs_last != FRAME) begin
                        failures++;
                        $display("FAIL frame_period got=%0d exp=%0d", n - fs_last, FRAME);
                    end
                end
                fs_last = n;
            end
        end
    endtask

    task automatic test_drain();
        bit ok;
        bit done = 1'b0;
        int prev_h = 0;
        int prev_v = 0;
        wait_pos(5, 3, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL drain_reach_pos h=%0d v=%0d exp h=5 v=3", h_count, v_count);
        end
        enable = 1'b0;
        for (int i = 0; i < 2 * FRAME && !done; i++) begin
            prev_h = int'(h_count);
            prev_v = int'(v_count);
            @(negedge clk);
            checks++;
            if (act !== model_out(m_busy, m_t)) begin
                failures++;
                $display("FAIL drain_scan act=%h exp=%h", act, model_out(m_busy, m_t));
            end
            if (!busy) done = 1'b1;
        end
        checks++;
        if (!done || prev_h != HT - 1 || prev_v != VT - 1) begin
            failures++;
            $display("FAIL drain_end done=%0d last h=%0d v=%0d exp h=%0d v=%0d",
                     done, prev_h, prev_v, HT - 1, VT - 1);
        end
        repeat (2 * LINE) begin
            @(negedge clk);
            checks++;
            if (act !== RST_VEC) begin
                failures++;
                $display("FAIL drain_idle act=%h exp=%h", act, RST_VEC);
            end
        end
    endtask

    task automatic test_reenable();
        int first_fs;
        bit dropped = 1'b0;
        bit raised = 1'b0;
        bit done = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        first_fs = ncyc;
        checks++;
        if (frame_start !== 1'b1) begin
            failures++;
            $display("FAIL reenable_start fs=%b exp=1", frame_start);
        end
        for (int i = 0; i < 2 * FRAME && !done; i++) begin
            @(negedge clk);
            checks++;
            if (act !== model_out(m_busy, m_t)) begin
                failures++;
                $display("FAIL reenable_scan act=%h exp=%h", act, model_out(m_busy, m_t));
            end
            if (frame_start) done = 1'b1;
            if (!dropped && h_count == 10'd2 && v_count == 10'd1) begin
                enable = 1'b0;
                dropped = 1'b1;
            end
            if (dropped && !raised && h_count == 10'd3 && v_count == 10'd6) begin
                enable = 1'b1;
                raised = 1'b1;
            end
        end
        checks++;
        if (!done || !raised || ncyc - first_fs != FRAME) begin
            failures++;
            $display("FAIL reenable_period got=%0d exp=%0d raised=%0d", ncyc - first_fs, FRAME, raised);
        end
    endtask

    task automatic test_boundary();
        bit armed = 1'b0;
        bit done = 1'b0;
        int n = 0;
        bit dropped = 1'b0;
        // Drop enable so that the final edge of a running frame samples it low.
        for (int i = 0; i < 2 * FRAME && !armed; i++) begin
            @(negedge clk);
            if (pix_ce && h_count == 10'(HT - 1) && v_count == 10'(VT - 1)) armed = 1'b1;
        end
        enable = 1'b0;
        for (int i = 0; i < 3 * FRAME && !done; i++) begin
            @(negedge clk);
            n++;
            checks++;
            if (act !== model_out(m_busy, m_t)) begin
                failures++;
                $display("FAIL boundary_drop_scan act=%h exp=%h", act, model_out(m_busy, m_t));
            end
            if (!busy) done = 1'b1;
        end
        checks++;
        if (!armed || !done || n != FRAME + 1) begin
            failures++;
            $display("FAIL boundary_drop_len got=%0d exp=%0d", n, FRAME + 1);
        end
        // Re-request on the final edge of a draining frame.
        enable = 1'b1;
        armed = 1'b0;
        for (int i = 0; i < 2 * FRAME && !armed; i++) begin
            @(negedge clk);
            if (!dropped && h_count == 10'd1) begin
                enable = 1'b0;
                dropped = 1'b1;
            end
            if (dropped && pix_ce && h_count == 10'(HT - 1) && v_count == 10'(VT - 1)) armed = 1'b1;
        end
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (!armed || frame_start !== 1'b1 || busy !== 1'b1 || h_count !== 10'd0 || v_count !== 10'd0) begin
            failures++;
            $display("FAIL boundary_rearm act=%h exp fs=1 busy=1 h=0 v=0", act);
        end
        repeat (LINE) begin
            @(negedge clk);
            checks++;
            if (act !== model_out(m_busy, m_t)) begin
                failures++;
                $display("FAIL boundary_rearm_scan act=%h exp=%h", act, model_out(m_busy, m_t));
            end
        end
    endtask

    task automatic test_random();
        int dwell = 0;
        repeat (3000) begin
            @(negedge clk);
            checks++;
            if (act !== model_out(m_busy, m_t)) begin
                failures++;
                $display("FAIL random_scan act=%h exp=%h", act, model_out(m_busy, m_t));
            end
            if (dwell == 0) begin
                enable = ~enable;
                dwell = int'($urandom_range(1, FRAME + LINE));
            end else begin
                dwell--;
            end
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        enable = 1'b1;
        wait_pos(6, 2, ok);
        checks++;
        if (!ok || busy !== 1'b1) begin
            failures++;
            $display("FAIL async_reach_pos h=%0d v=%0d busy=%b exp h=6 v=2 busy=1", h_count, v_count, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (act !== RST_VEC) begin
            failures++;
            $display("FAIL async_reset_immediate act=%h exp=%h", act, RST_VEC);
        end
        @(negedge clk);
        checks++;
        if (act !== RST_VEC) begin
            failures++;
            $display("FAIL async_reset_hold act=%h exp=%h", act, RST_VEC);
        end
        rst = 1'b0;
        repeat (2 * LINE) begin
            @(negedge clk);
            checks++;
            if (act !== model_out(m_busy, m_t)) begin
                failures++;
                $display("FAIL async_restart act=%h exp=%h", act, model_out(m_busy, m_t));
            end
        end
    endtask

    task automatic test_clkdiv1();
        logic [OW-1:0] a1, e1;
        int h, v;
        bit done = 1'b0;
        en1 = 1'b1;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            @(negedge clk);
            h = i % HT;
            v = (i / HT) % VT;
            a1 = {pix_ce1, h_count1, v_count1, hsync1, vsync1, video_on1, line_start1, frame_start1, busy1};
            e1 = {1'b1, 10'(h), 10'(v),
                  (h >= HA + HF && h < HA + HF + HSW) ? HSP : ~HSP,
                  (v >= VA + VF && v < VA + VF + VSW) ? VSP : ~VSP,
                  (h < HA) && (v < VA), h == 0, (h == 0) && (v == 0), 1'b1};
            checks++;
            if (a1 !== e1) begin
                failures++;
                $display("FAIL div1_scan i=%0d act=%h exp=%h", i, a1, e1);
            end
        end
        en1 = 1'b0;
        for (int i = 0; i < 3 * HT * VT && !done; i++) begin
            @(negedge clk);
            if (!busy1) done = 1'b1;
        end
        checks++;
        if (!done || pix_ce1 !== 1'b0 || h_count1 !== 10'd0 || v_count1 !== 10'd0) begin
            failures++;
            $display("FAIL div1_idle done=%0d ce=%b h=%0d v=%0d exp done=1 ce=0 h=0 v=0",
                     done, pix_ce1, h_count1, v_count1);
        end
    endtask

    initial begin
        test_reset();
        test_pixel_rate();
        test_frame();
        test_drain();
        test_reenable();
        test_boundary();
        test_random();
        test_async_reset();
        test_clkdiv1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog time=%0t exp finish before 2000000", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
